// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry FIFO between instruction fetch and dispatch.
// Each RV32I instruction is decoded as it is enqueued. The queue stores the
// decoded fields (op, rs1, rs2, rd, imm, pc, pd), not the raw instruction.
// Dispatch drains the head entry through a valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rdy               global enable; 0 freezes all state
//   flush             mispredict clear; empties the queue (needs rdy=1)
//   in_valid/in_ready fetch handshake; in_inst, in_pc, in_pd are the payload
//   out_valid/out_ready dispatch handshake; out_op/rs1/rs2/rd/imm/pc/pd
//                     carry the head entry (zeros with out_op=`NOP when empty)
//   count             occupancy, 0..DEPTH
//
// Optional feature: when DECODE_QUEUE_BYPASS_EN is defined, an instruction
// that arrives at an empty queue while dispatch is ready passes straight
// through combinationally and is never written into the queue.

`ifndef DECODE_QUEUE_OPS
`define DECODE_QUEUE_OPS
`define NOP   0
`define LUI   1
`define AUIPC 2
`define JAL   3
`define JALR  4
`define BEQ   5
`define BNE   6
`define BLT   7
`define BGE   8
`define BLTU  9
`define BGEU  10
`define LB    11
`define LH    12
`define LW    13
`define LBU   14
`define LHU   15
`define SB    16
`define SH    17
`define SW    18
`define ADDI  19
`define SLTI  20
`define SLTIU 21
`define XORI  22
`define ORI   23
`define ANDI  24
`define SLLI  25
`define SRLI  26
`define SRAI  27
`define ADD   28
`define SUB   29
`define SLL   30
`define SLT   31
`define SLTU  32
`define XOR   33
`define SRL   34
`define SRA   35
`define OR    36
`define AND   37
`endif

module decode_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int OP_W   = 6,
  parameter int NAME_W = 5,
  parameter int IMM_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [31:0]                in_inst,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic                       in_pd,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OP_W-1:0]            out_op,
  output logic [NAME_W-1:0]          out_rs1,
  output logic [NAME_W-1:0]          out_rs2,
  output logic [NAME_W-1:0]          out_rd,
  output logic [IMM_W-1:0]           out_imm,
  output logic [ADDR_W-1:0]          out_pc,
  output logic                       out_pd,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [NAME_W-1:0] rs1;
    logic [NAME_W-1:0] rs2;
    logic [NAME_W-1:0] rd;
    logic [IMM_W-1:0]  imm;
    logic [ADDR_W-1:0] pc;
    logic              pd;
  } entry_t;

  entry_t             dec;
  entry_t             head;
  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   cnt;
  logic               q_valid, push, pop, wr_en, bypass;

  // ---------------- decode ----------------
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [3:0]  fn;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_sel;
  logic [OP_W-1:0] op_sel;
  logic        bad, no_rs1, no_rs2, no_rd;

  assign opc    = in_inst[6:0];
  assign f3     = in_inst[14:12];
  assign fn     = {in_inst[30], in_inst[14:12]};
  assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                   in_inst[11:8], 1'b0};
  assign imm_u  = {in_inst[31:12], 12'b0};
  assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                   in_inst[30:21], 1'b0};
  assign imm_sh = {27'b0, in_inst[24:20]};

  always_comb begin
    op_sel  = OP_W'(`NOP);
    imm_sel = 32'b0;
    bad     = 1'b0;
    no_rs1  = 1'b0;
    no_rs2  = 1'b0;
    no_rd   = 1'b0;
    case (opc)
      7'b0110111: begin op_sel = OP_W'(`LUI);   imm_sel = imm_u; no_rs1 = 1'b1; no_rs2 = 1'b1; end
      7'b0010111: begin op_sel = OP_W'(`AUIPC); imm_sel = imm_u; no_rs1 = 1'b1; no_rs2 = 1'b1; end
      7'b1101111: begin op_sel = OP_W'(`JAL);   imm_sel = imm_j; no_rs1 = 1'b1; no_rs2 = 1'b1; end
      7'b1100111: begin
        imm_sel = imm_i; no_rs2 = 1'b1;
        if (f3 == 3'b000) op_sel = OP_W'(`JALR);
        else              bad    = 1'b1;
      end
      7'b1100011: begin
        imm_sel = imm_b; no_rd = 1'b1;
        case (f3)
          3'b000:  op_sel = OP_W'(`BEQ);
          3'b001:  op_sel = OP_W'(`BNE);
          3'b100:  op_sel = OP_W'(`BLT);
          3'b101:  op_sel = OP_W'(`BGE);
          3'b110:  op_sel = OP_W'(`BLTU);
          3'b111:  op_sel = OP_W'(`BGEU);
          default: bad    = 1'b1;
        endcase
      end
      7'b0000011: begin
        imm_sel = imm_i; no_rs2 = 1'b1;
        case (f3)
          3'b000:  op_sel = OP_W'(`LB);
          3'b001:  op_sel = OP_W'(`LH);
          3'b010:  op_sel = OP_W'(`LW);
          3'b100:  op_sel = OP_W'(`LBU);
          3'b101:  op_sel = OP_W'(`LHU);
          default: bad    = 1'b1;
        endcase
      end
      7'b0100011: begin
        imm_sel = imm_s; no_rd = 1'b1;
        case (f3)
          3'b000:  op_sel = OP_W'(`SB);
          3'b001:  op_sel = OP_W'(`SH);
          3'b010:  op_sel = OP_W'(`SW);
          default: bad    = 1'b1;
        endcase
      end
      7'b0010011: begin
        // inst[30] is only meaningful for the shifts; for the other OP-IMM
        // ops it is just an immediate bit.
        imm_sel = imm_i; no_rs2 = 1'b1;
        case (f3)
          3'b000: op_sel = OP_W'(`ADDI);
          3'b010: op_sel = OP_W'(`SLTI);
          3'b011: op_sel = OP_W'(`SLTIU);
          3'b100: op_sel = OP_W'(`XORI);
          3'b110: op_sel = OP_W'(`ORI);
          3'b111: op_sel = OP_W'(`ANDI);
          3'b001: begin
            imm_sel = imm_sh;
            if (!in_inst[30]) op_sel = OP_W'(`SLLI);
            else              bad    = 1'b1;
          end
          default: begin
            imm_sel = imm_sh;
            op_sel  = in_inst[30] ? OP_W'(`SRAI) : OP_W'(`SRLI);
          end
        endcase
      end
      7'b0110011: begin
        case (fn)
          4'b0000: op_sel = OP_W'(`ADD);
          4'b1000: op_sel = OP_W'(`SUB);
          4'b0001: op_sel = OP_W'(`SLL);
          4'b0010: op_sel = OP_W'(`SLT);
          4'b0011: op_sel = OP_W'(`SLTU);
          4'b0100: op_sel = OP_W'(`XOR);
          4'b0101: op_sel = OP_W'(`SRL);
          4'b1101: op_sel = OP_W'(`SRA);
          4'b0110: op_sel = OP_W'(`OR);
          4'b0111: op_sel = OP_W'(`AND);
          default: bad    = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    dec     = '0;
    dec.pc  = in_pc;
    dec.pd  = in_pd;
    if (!bad) begin
      dec.op  = op_sel;
      dec.imm = IMM_W'(imm_sel);
      dec.rs1 = no_rs1 ? '0 : NAME_W'(in_inst[19:15]);
      dec.rs2 = no_rs2 ? '0 : NAME_W'(in_inst[24:20]);
      dec.rd  = no_rd  ? '0 : NAME_W'(in_inst[11:7]);
    end else begin
      dec.op  = OP_W'(`NOP);
    end
  end

  // ---------------- queue control ----------------
  assign q_valid  = (cnt != '0);
  assign in_ready = (cnt < CNT_W'(DEPTH));
  assign push     = in_valid & in_ready & rdy & ~flush;
  assign pop      = q_valid & out_ready & rdy & ~flush;

`ifdef DECODE_QUEUE_BYPASS_EN
  // Empty queue and a ready consumer: hand the decoded word straight through.
  assign bypass = ~q_valid & push & out_ready;
`else
  assign bypass = 1'b0;
`endif

  assign wr_en     = push & ~bypass;
  assign out_valid = q_valid | bypass;

  always_comb begin
    head    = '0;
    head.op = OP_W'(`NOP);
    if (q_valid)     head = mem[rd_ptr];
    else if (bypass) head = dec;
  end

  assign out_op  = head.op;
  assign out_rs1 = head.rs1;
  assign out_rs2 = head.rs2;
  assign out_rd  = head.rd;
  assign out_imm = head.imm;
  assign out_pc  = head.pc;
  assign out_pd  = head.pd;
  assign count   = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (rdy) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (pop)   rd_ptr <= rd_ptr + 1'b1;
        case ({wr_en, pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // Payload storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= dec;
  end

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;

  localparam logic [5:0] OP_NOP = 6'd0,  OP_LUI = 6'd1,  OP_JAL = 6'd3,
                         OP_BEQ = 6'd5,  OP_SW  = 6'd18, OP_ADDI = 6'd19,
                         OP_SRAI = 6'd27, OP_SUB = 6'd29;

  logic        clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, flush = 1'b0;
  logic        in_valid = 1'b0, in_pd = 1'b0, out_ready = 1'b0;
  logic [31:0] in_inst = '0, in_pc = '0;
  logic        in_ready, out_valid, out_pd;
  logic [5:0]  out_op;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm, out_pc;
  logic [3:0]  count;

  decode_queue dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_pd(in_pd),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_pc(out_pc), .out_pd(out_pd), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, pc;
    logic        pd;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted head entry must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && rdy && !flush) begin
      exp_t a, e;
      a = {out_op, out_rs1, out_rs2, out_rd, out_imm, out_pc, out_pd};
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected act=%0h exp=none", a);
      end else begin
        e = sbq.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL pop_entry act=%0h exp=%0h", a, e);
        end
      end
    end
  end

  // Drive one instruction for one cycle; queue its expectation if accepted.
  task automatic send(input logic [31:0] inst, input logic [31:0] pc,
                      input logic [5:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [31:0] imm, input bit acc);
    in_valid = 1'b1; in_inst = inst; in_pc = pc; in_pd = pc[2];
    if (acc) sbq.push_back({op, rs1, rs2, rd, imm, pc, pc[2]});
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] k);
    return {k, 5'd0, 3'b000, rd, 7'b0010011};
  endfunction

  initial begin
    // ---- reset state ----
    #3;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_op", out_op, OP_NOP);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ---- async reset mid-stream ----
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(addi(5'(i + 1), 12'(i)), 32'h40 + 32'(4 * i), OP_ADDI, 0, 0, 5'(i + 1), 32'(i), 1'b1);
    chk("mid_count3", count, 3);
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_op", out_op, OP_NOP);
    chk("arst_in_ready", in_ready, 1);
    sbq.delete();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- single instruction and latency ----
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h1000; in_pd = 1'b0;
    sbq.push_back({OP_ADDI, 5'd0, 5'd0, 5'd1, 32'h5, 32'h1000, 1'b0});
    #1;
`ifdef DECODE_QUEUE_BYPASS_EN
    chk("lat_same_cycle_valid", out_valid, 1);
`else
    chk("lat_same_cycle_valid", out_valid, 0);
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifdef DECODE_QUEUE_BYPASS_EN
    chk("lat_next_count", count, 0);
    chk("lat_next_valid", out_valid, 0);
`else
    chk("lat_next_count", count, 1);
    chk("lat_next_valid", out_valid, 1);
`endif
    idle(1);
    chk("single_drained", count, 0);

    // ---- immediate formats ----
    send(32'h12345137, 32'h2000, OP_LUI,  0, 0, 2, 32'h12345000, 1'b1);
    send(32'hFFDFF0EF, 32'h2004, OP_JAL,  0, 0, 1, 32'hFFFFFFFC, 1'b1);
    send(32'hFE208EE3, 32'h2008, OP_BEQ,  1, 2, 0, 32'hFFFFFFFC, 1'b1);
    send(32'h0000000B, 32'h200C, OP_NOP,  0, 0, 0, 32'h0,        1'b1);
    send(32'h4010D093, 32'h2010, OP_SRAI, 1, 0, 1, 32'h1,        1'b1);
    send(32'h0020A423, 32'h2014, OP_SW,   1, 2, 0, 32'h8,        1'b1);
    send(32'h402081B3, 32'h2018, OP_SUB,  1, 2, 3, 32'h0,        1'b1);
    send(32'h40109093, 32'h201C, OP_NOP,  0, 0, 0, 32'h0,        1'b1);
    send(32'hFFF00293, 32'h2020, OP_ADDI, 0, 0, 5, 32'hFFFFFFFF, 1'b1);
    idle(2);
    chk("fmt_drained_count", count, 0);
    chk("fmt_sb_empty", sbq.size(), 0);

    // ---- full, overflow attempt, then wrap with concurrent push/pop ----
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      send(addi(5'(i + 1), 12'(3 * i + 1)), 32'h3000 + 32'(4 * i), OP_ADDI, 0, 0,
           5'(i + 1), 32'(3 * i + 1), 1'b1);
    chk("full_count", count, 8);
    chk("full_in_ready", in_ready, 0);
    send(addi(5'd9, 12'd99), 32'h3020, OP_ADDI, 0, 0, 9, 32'd99, 1'b0);
    chk("full_9th_ignored", count, 8);
    out_ready = 1'b1;
    // First cycle only pops (in_ready is low at DEPTH); afterwards push+pop.
    for (int i = 0; i < 20; i++)
      send(addi(5'(i + 10), 12'(i + 100)), 32'h4000 + 32'(4 * i), OP_ADDI, 0, 0,
           5'(i + 10), 32'(i + 100), i > 0);
    chk("wrap_count", count, 7);
    for (int n = 0; n < 20 && count != 0; n++) idle(1);
    chk("wrap_drained", count, 0);
    chk("wrap_sb_empty", sbq.size(), 0);

    // ---- flush ----
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(addi(5'(i + 1), 12'(i + 50)), 32'h5000 + 32'(4 * i), OP_ADDI, 0, 0,
           5'(i + 1), 32'(i + 50), 1'b1);
    chk("flush_pre_count", count, 5);
    rdy = 1'b0; flush = 1'b1;
    send(addi(5'd7, 12'd7), 32'h5100, OP_ADDI, 0, 0, 7, 32'd7, 1'b0);
    chk("flush_rdy0_count", count, 5);
    rdy = 1'b1; flush = 1'b1;
    sbq.delete();
    send(addi(5'd8, 12'd8), 32'h5104, OP_ADDI, 0, 0, 8, 32'd8, 1'b0);
    chk("flush_count", count, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_op", out_op, OP_NOP);
    out_ready = 1'b1;
    send(addi(5'd4, 12'd44), 32'h5200, OP_ADDI, 0, 0, 4, 32'd44, 1'b1);
    idle(2);
    chk("post_flush_count", count, 0);
    chk("post_flush_sb_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
